// File: rtl/bure_ex_muldiv_seq.sv
// ---------------------------------------------------------------------------------------------
// bure_ex_muldiv_seq
//
// Multi-cycle RV32M unit that sits beside the single-cycle EX ALU. One MUL/DIV/REM op is
// accepted from EX issue, run through a radix-2 shift-add multiplier or a restoring divider for
// DATA_WIDTH iterations, sign-corrected, and then returned over a valid/ready handshake. EX
// stalls ID on o_busy while an op is in flight.
//
// Divide-by-zero and signed overflow skip the iterative path. Their result is produced in the
// accept cycle and presented on the next cycle.
//
// Optional feature macro: BURE_MULDIV_FAST_ZERO_EN
//   When defined, a multiply with a zero operand, or a divide/remainder with a zero dividend
//   and a non-zero divisor, also takes the early path and returns 0. When the macro is
//   undefined these ops run the full iterative path. The results are identical; only the
//   latency differs.
//
// Ports
//   i_clk     clock, all logic on posedge
//   i_rstn    synchronous active-low reset
//   i_flush   kill any in-flight op (wins over i_valid)
//   i_valid   op request, taken when o_ready=1
//   o_ready   idle and able to accept
//   i_funct3  RV32M funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU)
//   i_rs1     lhs / dividend
//   i_rs2     rhs / divisor
//   o_valid   result valid, held until i_ready
//   i_ready   consumer takes the result
//   o_result  result word
//   o_busy    op accepted and not yet retired
// ---------------------------------------------------------------------------------------------

module bure_ex_muldiv_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_rs1,
    input  logic [DATA_WIDTH-1:0] i_rs2,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_busy
);

    localparam int unsigned W = DATA_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFixup,
        StDone
    } state_e;

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    state_e               state_q,  state_d;
    logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
    // Multiply: full 2W product, multiplier shifts out of the low half.
    // Divide:   high half is the partial remainder, low half shifts dividend in / quotient out.
    logic [2*W-1:0]       acc_q,    acc_d;
    logic [W-1:0]         opb_q,    opb_d;
    logic [2:0]           funct3_q, funct3_d;
    logic                 neg_q,    neg_d;
    logic [W-1:0]         result_q, result_d;
    logic                 valid_q,  valid_d;

    // -----------------------------------------------------------------------------------------
    // Accept-time decode: operand signedness, magnitudes and early-out cases
    // -----------------------------------------------------------------------------------------
    logic         in_is_div;
    logic         rs1_signed;
    logic         rs2_signed;
    logic         rs1_neg;
    logic         rs2_neg;
    logic [W-1:0] rs1_abs;
    logic [W-1:0] rs2_abs;
    logic         in_neg;
    logic         div_zero;
    logic         div_ovf;
    logic         fast_zero;
    logic         special;
    logic [W-1:0] special_res;

    always_comb begin
        in_is_div  = i_funct3[2];
        // MUL takes magnitudes unsigned: the low product word does not depend on signedness.
        rs1_signed = (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                     (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
        rs2_signed = (i_funct3 == 3'd1) || (i_funct3 == 3'd4) || (i_funct3 == 3'd6);

        rs1_neg = rs1_signed & i_rs1[W-1];
        rs2_neg = rs2_signed & i_rs2[W-1];
        rs1_abs = rs1_neg ? (~i_rs1 + 1'b1) : i_rs1;
        rs2_abs = rs2_neg ? (~i_rs2 + 1'b1) : i_rs2;

        // Remainder follows the dividend sign; product and quotient follow the sign XOR.
        if (in_is_div && i_funct3[1]) begin
            in_neg = rs1_neg;
        end else begin
            in_neg = rs1_neg ^ rs2_neg;
        end

        div_zero = in_is_div && (i_rs2 == '0);
        div_ovf  = ((i_funct3 == 3'd4) || (i_funct3 == 3'd6)) &&
                   (i_rs1 == {1'b1, {(W-1){1'b0}}}) && (i_rs2 == '1);

`ifdef BURE_MULDIV_FAST_ZERO_EN
        if (in_is_div) begin
            fast_zero = (i_rs1 == '0) && (i_rs2 != '0);
        end else begin
            fast_zero = (i_rs1 == '0) || (i_rs2 == '0);
        end
`else
        fast_zero = 1'b0;
`endif

        special = div_zero || div_ovf || fast_zero;

        // funct3[1] separates remainder (REM/REMU) from quotient (DIV/DIVU).
        if (div_zero) begin
            special_res = i_funct3[1] ? i_rs1 : '1;
        end else if (div_ovf) begin
            special_res = i_funct3[1] ? '0 : i_rs1;
        end else begin
            special_res = '0;
        end
    end

    // -----------------------------------------------------------------------------------------
    // One iteration of the multiplier and of the divider
    // -----------------------------------------------------------------------------------------
    logic           is_div_q;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic           div_ge;
    logic [2*W-1:0] div_next;
    logic           last_iter;

    always_comb begin
        is_div_q = funct3_q[2];

        // Add the multiplicand into the high half when the current multiplier bit is set,
        // then shift the whole product right by one (carry lands in the top bit).
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};

        // Shift the next dividend bit into the remainder and trial-subtract the divisor.
        // The remainder is always below the divisor, so a borrow shows up in bit W.
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = ~div_diff[W];
        div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};

        last_iter = (cnt_q == CNT_WIDTH'(W - 1));
    end

    // -----------------------------------------------------------------------------------------
    // Sign fixup and result word selection
    // -----------------------------------------------------------------------------------------
    logic [2*W-1:0] prod_signed;
    logic [W-1:0]   div_sel;
    logic [W-1:0]   fix_res;

    always_comb begin
        // Product negate is applied to the full 2W value so the high word borrows correctly.
        prod_signed = neg_q ? (~acc_q + 1'b1) : acc_q;
        div_sel     = funct3_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];

        if (is_div_q) begin
            fix_res = neg_q ? (~div_sel + 1'b1) : div_sel;
        end else if (funct3_q[1:0] == 2'd0) begin
            fix_res = prod_signed[W-1:0];
        end else begin
            fix_res = prod_signed[2*W-1:W];
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        result_d = result_q;
        valid_d  = valid_q;

        if (i_flush) begin
            // Flush wins everywhere, including over a same-cycle request or retire.
            state_d = StIdle;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        funct3_d = i_funct3;
                        neg_d    = in_neg;
                        acc_d    = {{W{1'b0}}, rs1_abs};
                        opb_d    = rs2_abs;
                        cnt_d    = '0;
                        if (special) begin
                            result_d = special_res;
                            valid_d  = 1'b1;
                            state_d  = StDone;
                        end else begin
                            state_d  = StCalc;
                        end
                    end
                end

                StCalc: begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (last_iter) begin
                        cnt_d   = '0;
                        state_d = StFixup;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end

                StFixup: begin
                    result_d = fix_res;
                    valid_d  = 1'b1;
                    state_d  = StDone;
                end

                StDone: begin
                    if (i_ready) begin
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end

                default: begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready  = (state_q == StIdle);
    assign o_busy   = (state_q != StIdle);
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule
